// File: rtl/onehot_prio_arb_mux.sv
// onehot_prio_arb_mux
//   Strict-priority arbiter with optional rotate-away-from-last-winner mode,
//   paired with a one-hot AND-OR data multiplexer.
//
//   The arbiter grants the lowest-index requester. When canchange is high, a
//   requester that won last cycle yields to any other requester. A lone
//   previous winner keeps its grant.
//
//   The mux ORs together every data lane whose select bit is set. An all-zero
//   select gives zero. A multi-hot select gives the OR of the selected lanes.
//
// Ports
//   clk        clock, rising-edge
//   rst        synchronous reset, active-high (clears the last-grant register)
//   canchange  enable rotation away from the previous winner
//   req        request vector, bit i = requester i
//   gnt        zero or one-hot grant, combinational, subset of req
//   mux_sel    mux select vector (any value legal)
//   mux_in     concatenated lanes, lane i = mux_in[i*W_DATA +: W_DATA]
//   mux_out    AND-OR selected data, combinational
module onehot_prio_arb_mux #(
  parameter int N_INPUTS = 2,
  parameter int W_DATA   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       canchange,
  input  logic [N_INPUTS-1:0]        req,
  output logic [N_INPUTS-1:0]        gnt,
  input  logic [N_INPUTS-1:0]        mux_sel,
  input  logic [N_INPUTS*W_DATA-1:0] mux_in,
  output logic [W_DATA-1:0]          mux_out
);

  localparam logic [N_INPUTS-1:0] ONE = N_INPUTS'(1);

  logic [N_INPUTS-1:0] last_gnt_q;
  logic [N_INPUTS-1:0] last_gnt_d;
  logic [N_INPUTS-1:0] held;
  logic [N_INPUTS-1:0] others;

  // Isolates the lowest set bit: v & -v in two's complement.
  function automatic logic [N_INPUTS-1:0] lowest_set(input logic [N_INPUTS-1:0] v);
    return v & (~v + ONE);
  endfunction

  assign held   = req & last_gnt_q;
  assign others = req & ~last_gnt_q;

  always_comb begin
    gnt = lowest_set(req);
    if (canchange) begin
      if ((held != '0) && (others != '0)) begin
        gnt = lowest_set(others);
      end else if (others == '0) begin
        // Previous winner is the only requester, or nobody requests.
        gnt = held;
      end
    end
  end

  assign last_gnt_d = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  // Gating with AND keeps unselected lanes, even X ones, out of the result.
  always_comb begin
    mux_out = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      mux_out = mux_out | (mux_in[i*W_DATA +: W_DATA] & {W_DATA{mux_sel[i]}});
    end
  end

endmodule

// File: tb/tb_onehot_prio_arb_mux.sv
module tb_onehot_prio_arb_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           canchange;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [N-1:0]   mux_sel;
  logic [N*W-1:0] mux_in;
  logic [W-1:0]   mux_out;

  int n_checks;
  int n_errors;

  logic [N-1:0] model_last;

  onehot_prio_arb_mux #(.N_INPUTS(N), .W_DATA(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .canchange (canchange),
    .req       (req),
    .gnt       (gnt),
    .mux_sel   (mux_sel),
    .mux_in    (mux_in),
    .mux_out   (mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
    logic [N-1:0] r;
    bit found;
    r = '0;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && v[i]) begin
        r[i] = 1'b1;
        found = 1;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] ref_gnt(input logic cc, input logic [N-1:0] r,
                                           input logic [N-1:0] last);
    logic [N-1:0] oth;
    if (!cc) return lowest(r);
    oth = r & ~last;
    if (((r & last) != 0) && (oth != 0)) return lowest(oth);
    if (oth == 0) return r & last;
    return lowest(r);
  endfunction

  function automatic logic [W-1:0] ref_mux(input logic [N-1:0] s, input logic [N*W-1:0] d);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++)
      if (s[i]) acc = acc | d[i*W +: W];
    return acc;
  endfunction

  // One clock cycle: drive at negedge, check mid-low-phase, advance model at posedge.
  task automatic cycle(input logic rst_v, input logic cc, input logic [N-1:0] r,
                       input logic [N-1:0] s, input logic [N*W-1:0] d,
                       input bit use_lit, input logic [N-1:0] lit, input string tag);
    logic [N-1:0] eg;
    rst = rst_v;
    canchange = cc;
    req = r;
    mux_sel = s;
    mux_in = d;
    #1;
    eg = ref_gnt(cc, r, model_last);
    check_val({tag, "_gnt"}, 32'(gnt), 32'(eg));
    if (use_lit) check_val({tag, "_lit"}, 32'(gnt), 32'(lit));
    check_val({tag, "_mux"}, 32'(mux_out), 32'(ref_mux(s, d)));
    check_val({tag, "_onehot0"}, 32'($onehot0(gnt)), 32'd1);
    check_val({tag, "_subset"}, 32'((gnt & ~r) == 0), 32'd1);
    @(posedge clk);
    model_last = rst_v ? '0 : eg;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_last = '0;
    rst = 1'b1;
    canchange = 1'b0;
    req = '0;
    mux_sel = '0;
    mux_in = '0;
    @(negedge clk);

    cycle(1, 0, 4'b0000, 4'b0000, 32'h0, 1, 4'b0000, "rst");

    // Strict priority directed
    cycle(0, 0, 4'b1010, 4'b0001, 32'h11223344, 1, 4'b0010, "sp_1010");
    cycle(0, 0, 4'b1000, 4'b0010, 32'h11223344, 1, 4'b1000, "sp_1000");
    cycle(0, 0, 4'b0000, 4'b0100, 32'h11223344, 1, 4'b0000, "sp_0000");

    // Sweep all request values with strict priority
    for (int v = 0; v < 16; v++)
      cycle(0, 0, 4'(v), 4'(v), 32'hA5C3_0FF0, 1, lowest(4'(v)), "sweep");

    // Rotation scenario
    cycle(1, 1, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, "cc_rst");
    cycle(0, 1, 4'b0011, 4'b0000, 32'h0, 1, 4'b0001, "cc_c1");
    cycle(0, 1, 4'b0011, 4'b0000, 32'h0, 1, 4'b0010, "cc_c2");
    cycle(0, 1, 4'b0011, 4'b0000, 32'h0, 1, 4'b0001, "cc_c3");
    for (int k = 0; k < 4; k++)
      cycle(0, 1, 4'b0010, 4'b0000, 32'h0, 1, 4'b0010, "cc_hold");

    // Mid-operation reset: last winner 0010 is forgotten after the reset edge
    cycle(1, 1, 4'b0011, 4'b0000, 32'h0, 1, 4'b0001, "mid_rst");
    cycle(0, 1, 4'b0011, 4'b0000, 32'h0, 1, 4'b0001, "post_rst");

    // Mux directed
    canchange = 1'b0;
    req = '0;
    mux_in = 32'hDDCCBBAA;
    mux_sel = 4'b0100;
    #1 check_val("mux_cc", 32'(mux_out), 32'h00CC);
    mux_sel = 4'b0000;
    #1 check_val("mux_zero", 32'(mux_out), 32'h0000);
    mux_sel = 4'b0011;
    #1 check_val("mux_or", 32'(mux_out), 32'h00BB);
    mux_sel = 4'b1111;
    #1 check_val("mux_all", 32'(mux_out), 32'h00FF);
    @(negedge clk);

    // Randomised run against the reference model
    for (int k = 0; k < 1000; k++)
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
            32'($urandom), 0, 4'b0000, "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
